// File: rtl/s1_transposer_tx.sv
// ---------------------------------------------------------------------------
// s1_transposer_tx
//
// This block reads the 18x8 register bank RB1 into a local buffer. It then
// sends the transposed contents as eight 18-bit words over the two-wire
// serial link (sen, sd) to the S2 receiver. Word k, bit j is RB1 row j, bit k.
// Each frame is 3 address bits (k, MSB first) followed by 18 data bits (MSB
// first), with sen held low for the whole frame. After each frame, sen is
// held high for GAP cycles.
//
// Handshake: the link has no back-pressure. sen=0 qualifies sd on every
// rising edge. A frame is exactly 21 contiguous sen-low cycles. sen never
// rises inside a frame, because the receiver treats that as an abort.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   RB1_RW   out  RB1 read/write select, constant 1 (read)
//   RB1_A    out  RB1 row address 0..17 (also serves as the LOAD row counter)
//   RB1_Q    in   RB1 read data, combinational from RB1_A
//   sen      out  serial enable, active-low
//   sd       out  serial data
//   S1_done  out  sticky completion flag
// ---------------------------------------------------------------------------
module s1_transposer_tx #(
   parameter int GAP = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       RB1_RW,
   output logic [4:0] RB1_A,
   input  logic [7:0] RB1_Q,
   output logic       sen,
   output logic       sd,
   output logic       S1_done
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_ADDR,
      S_DATA,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic [7:0]      row_buf [18];
   logic [2:0]      k, k_n, k_inc;
   logic [4:0]      cnt, cnt_n;     // bit position within ADDR / DATA
   logic [GW-1:0]   gcnt, gcnt_n;   // idle cycle within GAP
   logic [4:0]      a_n;
   logic            sen_n, sd_n, done_n;
   logic [17:0]     word_k;

   // Column k of the buffer is the word currently being sent.
   always_comb begin
      word_k = '0;
      for (int j = 0; j < 18; j++) begin
         word_k[j] = row_buf[j][k];
      end
   end

   assign k_inc = k + 3'd1;

   // Outputs are registered. Each branch therefore computes the value that
   // will be on sen/sd during the *next* cycle, including the first bit of
   // the state being entered.
   always_comb begin
      state_n = state;
      a_n     = RB1_A;
      k_n     = k;
      cnt_n   = cnt;
      gcnt_n  = gcnt;
      sen_n   = 1'b1;
      sd_n    = 1'b0;
      done_n  = S1_done;
      case (state)
         S_LOAD: begin
            if (RB1_A == 5'd17) begin
               state_n = S_ADDR;
               a_n     = 5'd0;
               k_n     = 3'd0;
               cnt_n   = 5'd0;
               sen_n   = 1'b0;
               sd_n    = 1'b0;          // k[2] of word 0
            end else begin
               a_n = RB1_A + 5'd1;
            end
         end
         S_ADDR: begin
            sen_n = 1'b0;
            if (cnt == 5'd2) begin
               state_n = S_DATA;
               cnt_n   = 5'd0;
               sd_n    = word_k[17];
            end else begin
               cnt_n = cnt + 5'd1;
               sd_n  = (cnt == 5'd0) ? k[1] : k[0];
            end
         end
         S_DATA: begin
            if (cnt == 5'd17) begin
               state_n = S_GAP;
               gcnt_n  = '0;
            end else begin
               cnt_n = cnt + 5'd1;
               sen_n = 1'b0;
               sd_n  = word_k[5'd16 - cnt];
            end
         end
         S_GAP: begin
            if (gcnt == GAP_LAST) begin
               if (k == 3'd7) begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_ADDR;
                  k_n     = k_inc;
                  cnt_n   = 5'd0;
                  sen_n   = 1'b0;
                  sd_n    = k_inc[2];
               end
            end else begin
               gcnt_n = gcnt + 1'b1;
            end
         end
         S_DONE: begin
            done_n = 1'b1;
         end
         default: begin
            state_n = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_LOAD;
         RB1_RW  <= 1'b1;
         RB1_A   <= 5'd0;
         sen     <= 1'b1;
         sd      <= 1'b0;
         S1_done <= 1'b0;
         k       <= 3'd0;
         cnt     <= 5'd0;
         gcnt    <= '0;
         for (int i = 0; i < 18; i++) begin
            row_buf[i] <= 8'd0;
         end
      end else begin
         state   <= state_n;
         RB1_RW  <= 1'b1;
         RB1_A   <= a_n;
         sen     <= sen_n;
         sd      <= sd_n;
         S1_done <= done_n;
         k       <= k_n;
         cnt     <= cnt_n;
         gcnt    <= gcnt_n;
         if (state == S_LOAD) begin
            row_buf[RB1_A] <= RB1_Q;
         end
      end
   end

endmodule

// File: tb/tb_s1_transposer_tx.sv
// ---------------------------------------------------------------------------
// tb_s1_transposer_tx
//
// Two instances share one RB1 image, with GAP=1 and GAP=3. The driver loads a
// pattern, computes the transposed words with plain bit arithmetic, and
// queues the expected frames. A monitor deserialises each sen/sd stream and
// acts as the S2 receiver (it writes RB2). It also checks frame contents,
// frame start cycles, reset values, RB1_A stepping and the S1_done cycle.
// ---------------------------------------------------------------------------
module tb_s1_transposer_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [18];
  logic        rw0, rw1, sen0, sen1, sd0, sd1, done0, done1;
  logic [4:0]  a0, a1;
  logic [7:0]  q0, q1;

  assign q0 = (a0 < 5'd18) ? mem[a0] : 8'h00;
  assign q1 = (a1 < 5'd18) ? mem[a1] : 8'h00;

  s1_transposer_tx #(.GAP(1)) u_gap1 (
    .clk(clk), .rst(rst), .RB1_RW(rw0), .RB1_A(a0), .RB1_Q(q0),
    .sen(sen0), .sd(sd0), .S1_done(done0)
  );

  s1_transposer_tx #(.GAP(3)) u_gap3 (
    .clk(clk), .rst(rst), .RB1_RW(rw1), .RB1_A(a1), .RB1_Q(q1),
    .sen(sen1), .sd(sd1), .S1_done(done1)
  );

  // cycle number relative to reset release
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int          checks = 0;
  int          failures = 0;
  logic [20:0] exp_q0[$];
  logic [20:0] exp_q1[$];
  logic [17:0] exp_w [8];
  logic [17:0] rb2 [2][8];
  int          nb [2];
  int          nfr [2];
  logic [20:0] sh [2];
  bit          done_seen [2];
  bit          rst_chk = 1'b0;
  bit          armed = 1'b0;
  bit          tmo_req = 1'b0;
  bit          tmo_seen = 1'b0;

  function automatic void chk(input string nm, input int g,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, g, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic        s_sen, s_sd, s_done, s_rw;
    logic [4:0]  s_a;
    logic [20:0] e;
    int          gp;
    if (tmo_req && !tmo_seen) begin
      tmo_seen = 1'b1;
      checks++;
      failures++;
      $display("FAIL timeout: S1_done not reached within cycle budget");
    end
    if (armed) begin
      if (rst) begin
        if (!rst_chk) begin
          rst_chk = 1'b1;
          exp_q0.delete();
          exp_q1.delete();
          for (int g = 0; g < 2; g++) begin
            s_rw   = (g == 0) ? rw0 : rw1;
            s_a    = (g == 0) ? a0 : a1;
            s_sen  = (g == 0) ? sen0 : sen1;
            s_sd   = (g == 0) ? sd0 : sd1;
            s_done = (g == 0) ? done0 : done1;
            chk("rst_rw", g, 32'(s_rw), 32'd1);
            chk("rst_a", g, 32'(s_a), 32'd0);
            chk("rst_sen", g, 32'(s_sen), 32'd1);
            chk("rst_sd", g, 32'(s_sd), 32'd0);
            chk("rst_done", g, 32'(s_done), 32'd0);
            nb[g] = 0;
            nfr[g] = 0;
            done_seen[g] = 1'b0;
            for (int k = 0; k < 8; k++) rb2[g][k] = 18'd0;
          end
        end
      end else begin
        rst_chk = 1'b0;
        for (int g = 0; g < 2; g++) begin
          gp     = (g == 0) ? 1 : 3;
          s_rw   = (g == 0) ? rw0 : rw1;
          s_a    = (g == 0) ? a0 : a1;
          s_sen  = (g == 0) ? sen0 : sen1;
          s_sd   = (g == 0) ? sd0 : sd1;
          s_done = (g == 0) ? done0 : done1;
          if (cyc >= 1 && cyc <= 17) begin
            chk("rb1_addr", g, {26'd0, s_rw, s_a}, {26'd0, 1'b1, 5'(cyc)});
          end
          if (done_seen[g]) begin
            chk("idle_after_done", g, {30'd0, s_sen, s_sd}, 32'd2);
          end
          if (s_sen == 1'b0) begin
            if (nb[g] == 0) begin
              chk("word_start", g, 32'(cyc), 32'(18 + nfr[g] * (21 + gp)));
            end
            sh[g] = {sh[g][19:0], s_sd};
            nb[g]++;
            if (nb[g] == 21) begin
              if (g == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : 21'h1FFFFF;
              else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : 21'h1FFFFF;
              chk("frame", g, 32'(sh[g]), 32'(e));
              rb2[g][sh[g][20:18]] = sh[g][17:0];
              nfr[g]++;
              nb[g] = 0;
            end
          end else if (nb[g] != 0) begin
            chk("sen_mid_word", g, 32'(nb[g]), 32'd0);
            nb[g] = 0;
          end
          if (s_done && !done_seen[g]) begin
            done_seen[g] = 1'b1;
            chk("done_cycle", g, 32'(cyc), 32'(18 + 8 * (21 + gp)));
            chk("frames_sent", g, 32'(nfr[g]), 32'd8);
            chk("queue_empty", g, 32'((g == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
            for (int k = 0; k < 8; k++) begin
              chk("rb2_row", g, 32'(rb2[g][k]), 32'(exp_w[k]));
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // pat: 0 identity, 1 checkerboard 8'hA5, 2 random
  task automatic start_test(input int pat);
    logic [2:0]  kk;
    logic [17:0] w;
    @(posedge clk);
    #2 rst = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    #1;
    for (int j = 0; j < 18; j++) begin
      case (pat)
        0:       mem[j] = 8'(j);
        1:       mem[j] = 8'hA5;
        default: mem[j] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int k = 0; k < 8; k++) begin
      w = 18'd0;
      for (int j = 0; j < 18; j++) begin
        if (((int'(mem[j]) >> k) & 1) == 1) w = w | (18'd1 << j);
      end
      exp_w[k] = w;
      kk = 3'(k);
      exp_q0.push_back({kk, w});
      exp_q1.push_back({kk, w});
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done0 && done1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!(done0 && done1)) tmo_req = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    start_test(0);
    wait_done();
    start_test(1);
    wait_done();
    // abort the GAP=1 instance in the data phase of word 5
    start_test(0);
    while (cyc < 135) @(negedge clk);
    start_test(0);
    wait_done();
    start_test(2);
    wait_done();
    start_test(2);
    wait_done();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s1_transposer_tx.md
# s1_transposer_tx

Upstream stage of the RB1→RB2 transfer path. After reset it reads the 18×8-bit register bank RB1 into an internal buffer and transposes it into eight 18-bit words. It then transmits each word over the two-wire serial link (sen, sd) to the downstream S2 receiver, which writes the words into RB2. It asserts S1_done when all eight words have been sent.

## Interface
Parameters:
- GAP, 1, number of sen-high idle cycles after each word; legal range ≥1.

Ports:
- clk  in  1  clock; all state changes occur on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RB1_RW  out  1  RB1 read/write select; 1 = read. Held at 1 at all times; this block never writes RB1.
- RB1_A  out  5  RB1 row address, range 0..17.
- RB1_Q  in  8  RB1 read data; combinational function of RB1_A, valid in the same cycle.
- sen  out  1  serial enable, active-low; low exactly while address and data bits are on sd.
- sd  out  1  serial data bit, sampled by the receiver on the rising edge while sen=0.
- S1_done  out  1  goes to 1 when the last word and its gap are complete, then stays at 1.

## Operation
- All outputs are registered. Reset values: RB1_RW=1, RB1_A=0, sen=1, sd=0, S1_done=0. Internal buffer and counters are cleared. State is LOAD.
- Transpose rule: word k (k=0..7), bit j (j=0..17) = RB1 row j, bit k. RB2 address of word k = k.
- States:
  - LOAD: the row counter r runs 0..17 and drives RB1_A=r. Each cycle, buf[r] ← RB1_Q and r increments. After r=17 is captured: RB1_A←0, k←0, next state ADDR.
  - ADDR: sen=0; sd = k[2], then k[1], then k[0] (MSB first), 3 cycles. Next state DATA.
  - DATA: sen=0; sd = word k bit 17 down to bit 0 (MSB first), 18 cycles. Next state GAP.
  - GAP: sen=1, sd=0 for GAP cycles. Then, if k=7, go to DONE; otherwise k←k+1 and go to ADDR.
  - DONE: sen=1, sd=0, S1_done=1. Terminal state; only rst leaves it.
- The address counter is 3 bits; k=7 is terminal and never wraps to 0.
- sen is never high in the middle of a word. The receiver treats a mid-word sen=1 as an abort, so no such glitch is allowed.
- Reset asserted mid-operation, in any state: immediately return to reset values; after release, the full LOAD and all 8 words are repeated from k=0.

## Timing
- Cycle 0 = first clock cycle after rst is released.
- LOAD occupies cycles 0–17, with RB1_A = cycle number.
- Word k starts at cycle 18 + k·(21+GAP).
- Within a word: sen is low for 21 consecutive cycles (3 address cycles, then 18 data cycles), followed by GAP cycles with sen high.
- With GAP=1: word k has sen low on cycles 18+22k … 38+22k and high on 39+22k. S1_done rises at cycle 194 (18 + 8·22).
- General rule: S1_done rises at cycle 18 + 8·(21+GAP).
- The minimum gap of 1 cycle matches the receiver's single RB2 write cycle after the last data bit.

## Test plan
- Reset check: rst pulse mid-cycle, then hold. Outputs must be RB1_RW=1, RB1_A=0, sen=1, sd=0, S1_done=0 asynchronously. RB1_A steps 0..17 on cycles 0–17.
- Identity pattern: RB1 row j = j (8'h00..8'h11), GAP=1. Word k bit j must equal bit k of j; e.g. word 0 = 18'h2AAAA, word 4 = 18'h30000. Check the address bits on sd are 000…111 in order, and S1_done rises at cycle 194.
- Checkerboard: all rows = 8'hA5. Words with k∈{0,2,5,7} must be 18'h3FFFF; the others must be 18'h00000. Check sen is low for exactly 21 cycles per word with no gaps inside a word.
- Parameter: GAP=3, identity data. The idle interval between words must be exactly 3 cycles, and S1_done must rise at cycle 210.
- Reset mid-DATA of word 5: output reverts immediately. After release, LOAD restarts at RB1_A=0 and words 0..7 are retransmitted correctly.
- End-to-end: connect to the S2 receiver with identity data. After S2_done, RB2 rows 0..7 must contain the transposed words listed in the identity-pattern test.
